fc_layer_stream: RTL and testbench
==================================

// Module: fc_layer_stream
// PURPOSE
//  Parametrised fully-connected layer engine, successor to the fixed-size FC layer.
//  Reads the input vector, per-neuron bias and row-major weights from a shared
//  single-port buffer, and accumulates at full width with saturation. It applies a
//  run-time selectable activation and writes N_OUT results back to the same buffer.
//  Only the input vector is held locally; weights are streamed, so depth scales with
//  the buffer, not with registers. Started by a one-cycle start/done handshake.
// PARAMETERS
//  DATA_W   16      signed fixed-point word width
//  FRAC     8       fractional bits (Q(DATA_W-FRAC).FRAC)
//  N_IN     32      input neurons
//  N_OUT    20      output neurons
//  ADDR_W   16      buffer address width
//  RD_LAT   2       buffer read latency in cycles (>=1)
//  X_BASE   0       input vector base address
//  B_BASE   32      bias base address (N_OUT words)
//  W_BASE   52      weight base, weight[o][i] at W_BASE+o*N_IN+i
//  O_BASE   0       output base address (may overlap X_BASE; X is already latched)
// PORTS
//  clk      in   1       clock, rising edge
//  reset    in   1       asynchronous, active-high reset
//  start    in   1       one-cycle pulse; ignored while busy=1
//  mode     in   2       activation: 00 none, 01 ReLU, 10 ReLU6, 11 = none; sampled at start
//  rdata    in   DATA_W  buffer read data, valid RD_LAT cycles after re=1
//  re       out  1       read strobe
//  we       out  1       write strobe (never high together with re)
//  addr     out  ADDR_W  buffer address for re/we
//  wdata    out  DATA_W  write data, valid when we=1
//  busy     out  1       high from the cycle after start until done
//  done     out  1       one-cycle pulse after the last write
// BEHAVIOUR
//  Reset: re, we, busy, done = 0; addr, wdata = 0; FSM = IDLE; x regs, acc, counters = 0.
//  FSM: IDLE -> LD_X -> LD_B -> MAC -> ACT -> WR -> (LD_B for next o | DONE) -> IDLE.
//  IDLE : start=1 latches mode and sets busy on the next edge.
//  LD_X : issue re at X_BASE..X_BASE+N_IN-1, one per cycle. A RD_LAT-deep valid shift
//         register steers each returning rdata into x[i]. Leave once all N_IN returned.
//  LD_B : issue re at B_BASE+o; the returned bias is sign-extended to ACC_W into acc.
//  MAC  : issue N_IN weight reads back-to-back. For each return:
//         acc += (x[i]*w) >>> FRAC. The product is 2*DATA_W signed, arithmetic shift
//         (floor). Leave after the N_IN-th return; no pipeline bubbles mid-row.
//  ACT  : sat = clamp(acc, -2^(DATA_W-1), 2^(DATA_W-1)-1). ReLU: max(sat, 0).
//         ReLU6: clamp(sat, 0, 6<<FRAC).
//  WR   : one cycle, we=1, addr=O_BASE+o, wdata=result; o++.
//  DONE : one cycle, done=1, busy=0 on the next edge; then IDLE.
//  ACC_W = 2*DATA_W + $clog2(N_IN) + 1, so no internal overflow; saturation occurs only in ACT.
//  Latency start->done pulse: 1 + (N_IN+RD_LAT) + N_OUT*(1+RD_LAT + N_IN+RD_LAT + 2) + 1.
//  Boundaries: start while busy is ignored with no state change. start and reset together:
//  reset wins. Reset mid-operation aborts with no further re/we, all outputs go to reset
//  values, and a later start runs a full fresh layer. N_IN=1 and N_OUT=1 must work.
//  re stays low in ACT/WR/DONE/IDLE, and addr holds its last value when re=we=0.
// STRUCTURE
//  fc_pkg: activation mode encodings (ACT_NONE/RELU/RELU6), FSM state enum,
//  sat_clamp and relu6 functions parametrised by DATA_W/FRAC.
//  Sub-module fc_mac: product, >>>FRAC, ACC_W accumulate, clear/load-bias controls.
//  The FSM, address generation and read-valid tracking stay in fc_layer_stream.
// TESTING (DATA_W=16, FRAC=8, N_IN=4, N_OUT=3, RD_LAT=2 unless noted)
//  1 x=0x0100 all, w=0x0100 all, b=0, mode=00 -> 3 writes of 0x0400 at O_BASE..+2, done once.
//  2 x=0x0400, w=0x0200, b=0: mode=10 -> 0x0600 each; mode=00 -> 0x2000 each.
//  3 x=0x0100, w=0xFF00, b=0x0080: mode=00 -> 0xFC80; mode=01 -> 0x0000.
//  4 x=w=b=0x7FFF mode=00 -> 0x7FFF; x=0x7FFF, w=0x8000 -> 0x8000 (no wrap).
//  5 start pulses every cycle during a run -> exactly one run, N_OUT writes, one done;
//    latency equals formula; re and we never both high.
//  6 reset asserted in MAC of o=1 -> outputs zero next cycle, no writes afterward;
//    then start -> correct full result for test 1 data; repeat with RD_LAT=1, N_IN=1.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared encodings, FSM states and activation helpers for the streaming FC layer engine.
package fc_pkg;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_RELU  = 2'b01;
  localparam logic [1:0] ACT_RELU6 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_X,
    S_LD_B,
    S_MAC,
    S_ACT,
    S_WR,
    S_DONE
  } state_e;

  // Clamp a wide signed value into the signed data_w-bit range.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned     data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Clamp into [0, 6.0] for a fixed-point value with frac fractional bits.
  function automatic logic signed [63:0] relu6(input logic signed [63:0] v,
                                               input int unsigned     frac);
    logic signed [63:0] lim;
    lim = 64'sd6 <<< frac;
    if (v < 64'sd0) return 64'sd0;
    if (v > lim) return lim;
    return v;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate: full-width product, floor shift by FRAC, wide accumulator
// with clear and bias-load controls.
module fc_mac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned ACC_W  = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load_b,
  input  logic              mac_en,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic [ACC_W-1:0]  acc
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] term;

  assign prod = $signed(PROD_W'($signed(x))) * $signed(PROD_W'($signed(w)));
  assign term = prod >>> FRAC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load_b) begin
      acc <= ACC_W'($signed(bias));
    end else if (mac_en) begin
      acc <= acc + ACC_W'(term);
    end
  end

endmodule

// File: rtl/fc_layer_stream.sv
// Fully-connected layer engine: latches the input vector, streams bias and weights from a
// shared single-port buffer, applies the selected activation and writes results back.
module fc_layer_stream
  import fc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned N_IN   = 32,
  parameter int unsigned N_OUT  = 20,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned X_BASE = 0,
  parameter int unsigned B_BASE = 32,
  parameter int unsigned W_BASE = 52,
  parameter int unsigned O_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] rdata,
  output logic              re,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N_IN) + 1;
  localparam int unsigned CNT_W = $clog2(N_IN + 1);
  localparam int unsigned O_W   = $clog2(N_OUT + 1);

  state_e              state, state_d;
  logic                re_d, we_d, busy_d, done_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    rd_cnt, rd_cnt_d, rt_cnt, rt_cnt_d;
  logic [O_W-1:0]      o_cnt, o_cnt_d;
  logic [ADDR_W-1:0]   w_ptr, w_ptr_d;
  logic [RD_LAT-1:0]   vld;
  logic                rvalid;
  logic [DATA_W-1:0]   x [N_IN];
  logic [DATA_W-1:0]   x_sel;
  logic                mac_clr, mac_load, mac_en;
  logic [ACC_W-1:0]    acc;
  logic signed [63:0]  sat_v, act_v;
  logic [DATA_W-1:0]   act_res;

  // Read returns arrive in issue order, RD_LAT cycles after each re.
  assign rvalid = vld[RD_LAT-1];

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (rt_cnt == CNT_W'(i)) x_sel = x[i];
    end
  end

  always_comb begin
    sat_v = sat_clamp(64'($signed(acc)), DATA_W);
    case (mode_q)
      ACT_RELU:  act_v = (sat_v < 64'sd0) ? 64'sd0 : sat_v;
      ACT_RELU6: act_v = relu6(sat_v, FRAC);
      ACT_NONE:  act_v = sat_v;
      default:   act_v = sat_v;
    endcase
    act_res = DATA_W'(act_v);
  end

  fc_mac #(
    .DATA_W(DATA_W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .load_b(mac_load),
    .mac_en(mac_en),
    .bias  (rdata),
    .x     (x_sel),
    .w     (rdata),
    .acc   (acc)
  );

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d  = state;
    re_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr;
    wdata_d  = wdata;
    busy_d   = busy;
    done_d   = 1'b0;
    mode_d   = mode_q;
    rd_cnt_d = rd_cnt;
    rt_cnt_d = rt_cnt;
    o_cnt_d  = o_cnt;
    w_ptr_d  = w_ptr;
    mac_clr  = 1'b0;
    mac_load = 1'b0;
    mac_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LD_X;
          busy_d   = 1'b1;
          mode_d   = mode;
          re_d     = 1'b1;
          addr_d   = ADDR_W'(X_BASE);
          rd_cnt_d = CNT_W'(1);
          rt_cnt_d = '0;
          o_cnt_d  = '0;
          w_ptr_d  = ADDR_W'(W_BASE);
          mac_clr  = 1'b1;
        end
      end
      S_LD_X: begin
        if (rd_cnt < CNT_W'(N_IN)) begin
          re_d     = 1'b1;
          addr_d   = ADDR_W'(X_BASE) + ADDR_W'(rd_cnt);
          rd_cnt_d = rd_cnt + CNT_W'(1);
        end
        if (rvalid) begin
          rt_cnt_d = rt_cnt + CNT_W'(1);
          if (rt_cnt == CNT_W'(N_IN - 1)) begin
            state_d = S_LD_B;
            re_d    = 1'b1;
            addr_d  = ADDR_W'(B_BASE) + ADDR_W'(o_cnt);
          end
        end
      end
      S_LD_B: begin
        if (rvalid) begin
          mac_load = 1'b1;
          state_d  = S_MAC;
          re_d     = 1'b1;
          addr_d   = w_ptr;
          w_ptr_d  = w_ptr + ADDR_W'(1);
          rd_cnt_d = CNT_W'(1);
          rt_cnt_d = '0;
        end
      end
      S_MAC: begin
        if (rd_cnt < CNT_W'(N_IN)) begin
          re_d     = 1'b1;
          addr_d   = w_ptr;
          w_ptr_d  = w_ptr + ADDR_W'(1);
          rd_cnt_d = rd_cnt + CNT_W'(1);
        end
        if (rvalid) begin
          mac_en   = 1'b1;
          rt_cnt_d = rt_cnt + CNT_W'(1);
          if (rt_cnt == CNT_W'(N_IN - 1)) state_d = S_ACT;
        end
      end
      S_ACT: begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(O_BASE) + ADDR_W'(o_cnt);
        wdata_d = act_res;
        state_d = S_WR;
      end
      S_WR: begin
        o_cnt_d = o_cnt + O_W'(1);
        if (o_cnt == O_W'(N_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LD_B;
          re_d    = 1'b1;
          addr_d  = ADDR_W'(B_BASE) + ADDR_W'(o_cnt) + ADDR_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      re     <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= '0;
      rd_cnt <= '0;
      rt_cnt <= '0;
      o_cnt  <= '0;
      w_ptr  <= '0;
      vld    <= '0;
      for (int i = 0; i < int'(N_IN); i++) x[i] <= '0;
    end else begin
      state  <= state_d;
      re     <= re_d;
      we     <= we_d;
      addr   <= addr_d;
      wdata  <= wdata_d;
      busy   <= busy_d;
      done   <= done_d;
      mode_q <= mode_d;
      rd_cnt <= rd_cnt_d;
      rt_cnt <= rt_cnt_d;
      o_cnt  <= o_cnt_d;
      w_ptr  <= w_ptr_d;
      vld    <= RD_LAT'({vld, re});
      if (state == S_LD_X && rvalid) begin
        for (int i = 0; i < int'(N_IN); i++) begin
          if (rt_cnt == CNT_W'(i)) x[i] <= rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream: a 4x3/RD_LAT=2 instance and a 1x2/RD_LAT=1 instance,
// each backed by a behavioural buffer with matching read latency.
module tb_fc_layer_stream;

  localparam int A_NI = 4, A_NO = 3, A_RL = 2, A_XB = 0, A_BB = 32, A_WB = 52, A_OB = 0;
  localparam int B_NI = 1, B_NO = 2, B_RL = 1, B_XB = 0, B_BB = 8,  B_WB = 16, B_OB = 0;
  localparam int A_LAT = 1 + (A_NI + A_RL) + A_NO * (1 + A_RL + A_NI + A_RL + 2) + 1;
  localparam int B_LAT = 1 + (B_NI + B_RL) + B_NO * (1 + B_RL + B_NI + B_RL + 2) + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [1:0]  mode;
  logic [15:0] rdata_a, rdata_b, addr_a, addr_b, wdata_a, wdata_b;
  logic        re_a, we_a, busy_a, done_a, re_b, we_b, busy_b, done_b;

  always #5 clk = ~clk;

  fc_layer_stream #(
    .DATA_W(16), .FRAC(8), .N_IN(A_NI), .N_OUT(A_NO), .ADDR_W(16), .RD_LAT(A_RL),
    .X_BASE(A_XB), .B_BASE(A_BB), .W_BASE(A_WB), .O_BASE(A_OB)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode), .rdata(rdata_a),
    .re(re_a), .we(we_a), .addr(addr_a), .wdata(wdata_a), .busy(busy_a), .done(done_a)
  );

  fc_layer_stream #(
    .DATA_W(16), .FRAC(8), .N_IN(B_NI), .N_OUT(B_NO), .ADDR_W(16), .RD_LAT(B_RL),
    .X_BASE(B_XB), .B_BASE(B_BB), .W_BASE(B_WB), .O_BASE(B_OB)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode), .rdata(rdata_b),
    .re(re_b), .we(we_b), .addr(addr_b), .wdata(wdata_b), .busy(busy_b), .done(done_b)
  );

  // Behavioural buffers; DUT writes are logged rather than stored.
  logic [15:0] mem_a [64];
  logic [15:0] mem_b [32];
  logic [15:0] pipe_a [2];
  logic [15:0] pipe_b;

  always @(posedge clk) begin
    pipe_a[0] <= re_a ? mem_a[addr_a[5:0]] : 16'hDEAD;
    pipe_a[1] <= pipe_a[0];
    pipe_b    <= re_b ? mem_b[addr_b[4:0]] : 16'hDEAD;
  end
  assign rdata_a = pipe_a[1];
  assign rdata_b = pipe_b;

  int          cyc = 0;
  int          wn[2] = '{0, 0};
  int          dn[2] = '{0, 0};
  int          rn[2] = '{0, 0};
  bit          both_hi[2] = '{1'b0, 1'b0};
  logic [15:0] wl_addr[2][64];
  logic [15:0] wl_data[2][64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we_a) begin
      wl_addr[0][wn[0] % 64] <= addr_a;
      wl_data[0][wn[0] % 64] <= wdata_a;
      wn[0] <= wn[0] + 1;
    end
    if (we_b) begin
      wl_addr[1][wn[1] % 64] <= addr_b;
      wl_data[1][wn[1] % 64] <= wdata_b;
      wn[1] <= wn[1] + 1;
    end
    if (done_a) dn[0] <= dn[0] + 1;
    if (done_b) dn[1] <= dn[1] + 1;
    if (re_a) rn[0] <= rn[0] + 1;
    if (re_b) rn[1] <= rn[1] + 1;
    if (re_a && we_a) both_hi[0] <= 1'b1;
    if (re_b && we_b) both_hi[1] <= 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic done_of(input int s);
    return (s == 1) ? done_b : done_a;
  endfunction

  function automatic logic re_of(input int s);
    return (s == 1) ? re_b : re_a;
  endfunction

  function automatic logic [15:0] addr_of(input int s);
    return (s == 1) ? addr_b : addr_a;
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s == 1) start_b = v;
    else start_a = v;
  endtask

  task automatic load_a(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < A_NI; i++) mem_a[A_XB + i] = xv;
    for (int o = 0; o < A_NO; o++) mem_a[A_BB + o] = bv;
    for (int k = 0; k < A_NI * A_NO; k++) mem_a[A_WB + k] = wv;
  endtask

  // One full layer run; mode is flipped after start to confirm it was latched.
  task automatic run(input int s, input logic [1:0] m, input logic [15:0] e0,
                     input logic [15:0] e1, input logic [15:0] e2, input int nout,
                     input int ob, input int lat, input bit spam, input string nm);
    int          w0, d0, t0, td;
    bit          seen;
    logic [15:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    w0 = wn[s]; d0 = dn[s];
    @(negedge clk); mode = m; set_start(s, 1'b1); t0 = cyc;
    @(negedge clk); mode = ~m; set_start(s, spam);
    seen = 1'b0; td = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (done_of(s)) begin seen = 1'b1; td = cyc; end
      else @(negedge clk);
    end
    set_start(s, 1'b0);
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(td - t0), 32'(lat));
    repeat (4) @(negedge clk);
    chk({nm, " n_writes"}, 32'(wn[s] - w0), 32'(nout));
    chk({nm, " n_done"}, 32'(dn[s] - d0), 32'd1);
    for (int o = 0; o < nout && o < 3; o++) begin
      chk($sformatf("%s wr%0d_addr", nm, o), 32'(wl_addr[s][(w0 + o) % 64]), 32'(ob + o));
      chk($sformatf("%s wr%0d_data", nm, o), 32'(wl_data[s][(w0 + o) % 64]), 32'(e[o]));
    end
  endtask

  // Abort a run with reset once the first weight read of neuron 1 is issued.
  task automatic reset_mid(input int s, input logic [15:0] w1_addr, input string nm);
    bit found;
    int w0, r0;
    @(negedge clk); mode = 2'b00; set_start(s, 1'b1);
    @(negedge clk); set_start(s, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (re_of(s) && addr_of(s) == w1_addr) found = 1'b1;
      else @(negedge clk);
    end
    chk({nm, " reached_mac_o1"}, 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    if (s == 1) begin
      chk({nm, " ctl_after_reset"}, {28'd0, re_b, we_b, busy_b, done_b}, 32'd0);
      chk({nm, " addr_after_reset"}, 32'(addr_b), 32'd0);
      chk({nm, " wdata_after_reset"}, 32'(wdata_b), 32'd0);
    end else begin
      chk({nm, " ctl_after_reset"}, {28'd0, re_a, we_a, busy_a, done_a}, 32'd0);
      chk({nm, " addr_after_reset"}, 32'(addr_a), 32'd0);
      chk({nm, " wdata_after_reset"}, 32'(wdata_a), 32'd0);
    end
    w0 = wn[s]; r0 = rn[s];
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    chk({nm, " no_writes_after_abort"}, 32'(wn[s] - w0), 32'd0);
    chk({nm, " no_reads_after_abort"}, 32'(rn[s] - r0), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] b;
    logic [1:0]  mode;
    logic [15:0] exp;
    bit          spam;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"unity",       16'h0100, 16'h0100, 16'h0000, 2'b00, 16'h0400, 1'b1};
    vecs[1]  = '{"relu6_clip",  16'h0400, 16'h0200, 16'h0000, 2'b10, 16'h0600, 1'b0};
    vecs[2]  = '{"none_big",    16'h0400, 16'h0200, 16'h0000, 2'b00, 16'h2000, 1'b0};
    vecs[3]  = '{"relu_pos",    16'h0400, 16'h0200, 16'h0000, 2'b01, 16'h2000, 1'b0};
    vecs[4]  = '{"neg_bias",    16'h0100, 16'hFF00, 16'h0080, 2'b00, 16'hFC80, 1'b0};
    vecs[5]  = '{"relu_neg",    16'h0100, 16'hFF00, 16'h0080, 2'b01, 16'h0000, 1'b0};
    vecs[6]  = '{"mode3_none",  16'h0100, 16'hFF00, 16'h0080, 2'b11, 16'hFC80, 1'b0};
    vecs[7]  = '{"relu6_neg",   16'h0100, 16'hFF00, 16'h0080, 2'b10, 16'h0000, 1'b0};
    vecs[8]  = '{"sat_pos",     16'h7FFF, 16'h7FFF, 16'h7FFF, 2'b00, 16'h7FFF, 1'b0};
    vecs[9]  = '{"sat_neg",     16'h7FFF, 16'h8000, 16'h0000, 2'b00, 16'h8000, 1'b0};
    vecs[10] = '{"floor_shift", 16'h0001, 16'hFFFF, 16'h0000, 2'b00, 16'hFFFC, 1'b0};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 2'b00;
    for (int i = 0; i < 64; i++) mem_a[i] = 16'h0000;
    for (int i = 0; i < 32; i++) mem_b[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_ctl_a", {28'd0, re_a, we_a, busy_a, done_a}, 32'd0);
    chk("reset_addr_a", 32'(addr_a), 32'd0);
    chk("reset_wdata_a", 32'(wdata_a), 32'd0);
    chk("reset_ctl_b", {28'd0, re_b, we_b, busy_b, done_b}, 32'd0);

    // start coincident with reset: reset wins
    start_a = 1'b1;
    @(negedge clk);
    chk("start_with_reset_busy", 32'(busy_a), 32'd0);
    chk("start_with_reset_re", 32'(re_a), 32'd0);
    start_a = 1'b0; reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      load_a(vecs[v].x, vecs[v].w, vecs[v].b);
      run(0, vecs[v].mode, vecs[v].exp, vecs[v].exp, vecs[v].exp, A_NO, A_OB, A_LAT,
          vecs[v].spam, vecs[v].name);
    end

    // Distinct per-neuron data: x = 1..4, w[o][i] = 4o+i+1, b = 0x10/0x20/0x30
    for (int i = 0; i < A_NI; i++) mem_a[A_XB + i] = 16'((i + 1) << 8);
    for (int o = 0; o < A_NO; o++) mem_a[A_BB + o] = 16'((o + 1) * 16);
    for (int k = 0; k < A_NI * A_NO; k++) mem_a[A_WB + k] = 16'((k + 1) << 8);
    run(0, 2'b00, 16'h1E10, 16'h4620, 16'h6E30, A_NO, A_OB, A_LAT, 1'b0, "ramp");

    load_a(16'h0100, 16'h0100, 16'h0000);
    reset_mid(0, 16'(A_WB + A_NI), "abort_a");
    run(0, 2'b00, 16'h0400, 16'h0400, 16'h0400, A_NO, A_OB, A_LAT, 1'b0, "rerun_a");

    mem_b[B_XB] = 16'h0180;
    mem_b[B_BB] = 16'h0010; mem_b[B_BB + 1] = 16'h0020;
    mem_b[B_WB] = 16'h0200; mem_b[B_WB + 1] = 16'h0300;
    run(1, 2'b00, 16'h0310, 16'h04A0, 16'h0000, B_NO, B_OB, B_LAT, 1'b1, "small_b");
    reset_mid(1, 16'(B_WB + 1), "abort_b");
    run(1, 2'b00, 16'h0310, 16'h04A0, 16'h0000, B_NO, B_OB, B_LAT, 1'b0, "rerun_b");

    chk("re_we_overlap_a", 32'(both_hi[0]), 32'd0);
    chk("re_we_overlap_b", 32'(both_hi[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
